// File: rtl/fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync
// Synchronous FIFO, registered read data, wrap-bit pointers for full/empty.
// Revision : 1.0
// ============================================================================
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 4
) (
  input  logic                  clk_i,
  input  logic                  resetn_i,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  w_en,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  fifo_empty,
  output logic                  fifo_full
);

  localparam int              DEPTH   = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS:0] PTR_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] fifo_mem_reg [DEPTH];
  logic [ADDR_BITS:0]    w_ptr_r;
  logic [ADDR_BITS:0]    r_ptr_r;
  logic [ADDR_BITS:0]    w_ptr_d;
  logic [ADDR_BITS:0]    r_ptr_d;
  logic [DATA_WIDTH-1:0] data_out_d;
  logic                  w_en_r;
  logic                  r_en_r;

  // Same slot with opposite wrap bits means the writer is a full lap ahead.
  assign fifo_empty = (w_ptr_r == r_ptr_r);
  assign fifo_full  = (w_ptr_r[ADDR_BITS] != r_ptr_r[ADDR_BITS]) &&
                      (w_ptr_r[ADDR_BITS-1:0] == r_ptr_r[ADDR_BITS-1:0]);

  assign r_en_r = r_en & ~fifo_empty;
  assign w_en_r = w_en & (~fifo_full | r_en_r);

  always_comb begin
    w_ptr_d    = w_ptr_r;
    r_ptr_d    = r_ptr_r;
    data_out_d = data_out;
    if (w_en_r) begin
      w_ptr_d = w_ptr_r + PTR_ONE;
    end
    if (r_en_r) begin
      r_ptr_d    = r_ptr_r + PTR_ONE;
      data_out_d = fifo_mem_reg[r_ptr_r[ADDR_BITS-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      w_ptr_r  <= '0;
      r_ptr_r  <= '0;
      data_out <= '0;
    end else begin
      w_ptr_r  <= w_ptr_d;
      r_ptr_r  <= r_ptr_d;
      data_out <= data_out_d;
    end
  end

  // Storage is deliberately left unreset; emptiness hides stale words.
  always_ff @(posedge clk_i) begin
    if (w_en_r) begin
      fifo_mem_reg[w_ptr_r[ADDR_BITS-1:0]] <= data_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync
// Directed vector bench for fifo_sync (default 8-bit x 16 configuration).
// Revision : 1.0
// ============================================================================
module tb_fifo_sync;

  logic       clk;
  logic       resetn;
  logic [7:0] data_in;
  logic       w_en;
  logic       r_en;
  logic [7:0] data_out;
  logic       fifo_empty;
  logic       fifo_full;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] din;
    logic [7:0] dout;
    logic       empty;
    logic       full;
  } vec_t;

  vec_t vecs[$];

  fifo_sync #(.DATA_WIDTH(8), .ADDR_BITS(4)) dut (
    .clk_i     (clk),
    .resetn_i  (resetn),
    .data_in   (data_in),
    .w_en      (w_en),
    .r_en      (r_en),
    .data_out  (data_out),
    .fifo_empty(fifo_empty),
    .fifo_full (fifo_full)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic w, input logic r, input logic [7:0] d);
    w_en    = w;
    r_en    = r;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
    resetn  = 1'b0;
    #3;
    resetn  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic w, logic r, logic [7:0] din, logic [7:0] dout,
                              logic empty, logic full);
    vec_t v;
    v.w = w; v.r = r; v.din = din; v.dout = dout; v.empty = empty; v.full = full;
    return v;
  endfunction

  initial begin
    // Fill 0x01..0x10, a dropped 17th write, drain, an ignored 17th read,
    // then streaming read+write starting from empty.
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b1, 1'b0, 8'(i + 1), 8'h00, 1'b0, (i == 15)));
    vecs.push_back(mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1));
    for (int i = 0; i < 16; i++) vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'(i + 1), (i == 15), 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'h10, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hA0, 8'h10, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hA1, 8'hA0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hA2, 8'hA1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 8'hA3, 8'hA2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 8'hA3, 1'b1, 1'b0));

    resetn  = 1'b0;
    w_en    = 1'b0;
    r_en    = 1'b0;
    data_in = 8'h00;
    #12;
    check("rst.empty", 32'(fifo_empty), 32'd1);
    check("rst.full", 32'(fifo_full), 32'd0);
    check("rst.dout", 32'(data_out), 32'h00);
    check("rst.wptr", 32'(dut.w_ptr_r), 32'd0);
    check("rst.rptr", 32'(dut.r_ptr_r), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rel.empty", 32'(fifo_empty), 32'd1);
    check("rel.full", 32'(fifo_full), 32'd0);
    check("rel.dout", 32'(data_out), 32'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].w, vecs[i].r, vecs[i].din);
      check($sformatf("vec%0d.dout", i), 32'(data_out), 32'(vecs[i].dout));
      check($sformatf("vec%0d.empty", i), 32'(fifo_empty), 32'(vecs[i].empty));
      check($sformatf("vec%0d.full", i), 32'(fifo_full), 32'(vecs[i].full));
      if (i == 16) check("drop.wptr", 32'(dut.w_ptr_r), 32'd16);
    end

    // Full FIFO with 20 cycles of simultaneous read/write across the wrap.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i + 1));
    check("wrap.prefull", 32'(fifo_full), 32'd1);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b1, 8'(8'h40 + k));
      check($sformatf("wrap%0d.dout", k), 32'(data_out),
            (k < 16) ? 32'(k + 1) : 32'(8'h40 + k - 16));
      check($sformatf("wrap%0d.full", k), 32'(fifo_full), 32'd1);
      if (k == 15) begin
        check("wrap.rmsb", 32'(dut.r_ptr_r[4]), 32'd1);
        check("wrap.wmsb", 32'(dut.w_ptr_r[4]), 32'd0);
      end
    end

    // Reset asserted mid-stream with five entries stored.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'(8'h61 + i));
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("mid.dout_pre", 32'(data_out), 32'h61);
    check("mid.empty_pre", 32'(fifo_empty), 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    check("mid.empty", 32'(fifo_empty), 32'd1);
    check("mid.dout", 32'(data_out), 32'h00);
    check("mid.full", 32'(fifo_full), 32'd0);
    #3;
    resetn = 1'b1;
    step(1'b1, 1'b0, 8'h77);
    check("resume.empty", 32'(fifo_empty), 32'd0);
    step(1'b0, 1'b1, 8'h00);
    check("resume.dout", 32'(data_out), 32'h77);
    check("resume.empty2", 32'(fifo_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_sync.md
FIFO_SYNC -- requirements
Module: fifo_sync

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the width of each data word in bits.
REQ-002 The block SHALL have parameter ADDR_BITS, default 4, meaning the address width; depth N = 2**ADDR_BITS entries (16 by default).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port resetn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port data_in, input, DATA_WIDTH bits: the write data.
REQ-006 The block SHALL have port w_en, input, 1 bit: the write request.
REQ-007 The block SHALL have port r_en, input, 1 bit: the read request.
REQ-008 The block SHALL have port data_out, output, DATA_WIDTH bits: the registered read data.
REQ-009 The block SHALL have port fifo_empty, output, 1 bit: asserted when the FIFO holds 0 entries.
REQ-010 The block SHALL have port fifo_full, output, 1 bit: asserted when the FIFO holds N entries.
REQ-011 The block SHALL expose these internal signals for hierarchical probing by benches: fifo_mem_reg[0..N-1] (storage), w_ptr_r and r_ptr_r (ADDR_BITS+1 bits each), w_en_r and r_en_r (qualified enables).

Function
REQ-012 Storage SHALL be N words of DATA_WIDTH bits, addressed by pointer bits [ADDR_BITS-1:0].
REQ-013 w_ptr_r and r_ptr_r SHALL be ADDR_BITS+1 bits wide and increment modulo 2**(ADDR_BITS+1); the MSB acts as a wrap flag.
REQ-014 fifo_empty SHALL equal (w_ptr_r == r_ptr_r), decoded combinationally from the registered pointers.
REQ-015 fifo_full SHALL equal (MSBs differ AND low ADDR_BITS equal), decoded combinationally from the registered pointers.
REQ-016 r_en_r SHALL equal r_en AND NOT fifo_empty.
REQ-017 w_en_r SHALL equal w_en AND (NOT fifo_full OR r_en_r); a write on a full FIFO is accepted only with a simultaneous accepted read.
REQ-018 On a rising edge with w_en_r=1: fifo_mem_reg[w_ptr_r low bits] <= data_in and w_ptr_r increments by 1.
REQ-019 On a rising edge with r_en_r=1: data_out <= fifo_mem_reg[r_ptr_r low bits] and r_ptr_r increments by 1; read latency is 1 clock from the sampling edge.
REQ-020 data_out SHALL hold its previous value on any edge where r_en_r=0.
REQ-021 A write with fifo_full=1 and no accepted read SHALL be dropped: no memory change, no pointer change, no error flag.
REQ-022 A read with fifo_empty=1 SHALL be ignored, even if a write occurs on the same edge; data_out is not updated, and the new word is readable from the next cycle on.
REQ-023 Simultaneous accepted read and write SHALL keep occupancy unchanged; a read on a full FIFO returns the oldest word, never the word being written.
REQ-024 Data SHALL be returned in strict write order across pointer wrap-around.
REQ-025 Flags SHALL update in the cycle following the edge that changes occupancy; there are no almost-full or almost-empty flags.

Reset
REQ-026 While resetn_i=0 (asynchronous assert): w_ptr_r=0, r_ptr_r=0, data_out=0, fifo_empty=1, fifo_full=0.
REQ-027 Memory contents SHALL NOT be reset; no stale word is readable after reset because the FIFO is empty.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries immediately; operation resumes on the first rising edge after resetn_i deasserts.

Verification
REQ-029 Reset: resetn_i=0, then release with w_en=r_en=0 -> fifo_empty=1, fifo_full=0, data_out=0, both pointers 0.
REQ-030 Fill: 16 consecutive writes of 0x01..0x10 with r_en=0 -> fifo_full=1 after the 16th edge; a 17th write of 0xFF is dropped and w_ptr_r stays 16.
REQ-031 Drain: 16 reads after the fill -> data_out sequence 0x01..0x10, each 1 cycle after its read edge; fifo_empty=1 after the 16th; a 17th read leaves data_out=0x10.
REQ-032 Simultaneous read/write: w_en=r_en=1 continuously from empty -> the first read is ignored; thereafter data_out trails data_in by 2 cycles and occupancy stays 1.
REQ-033 Full plus simultaneous read/write, and wrap: from full, assert w_en and r_en for 20 cycles -> fifo_full stays 1, outputs follow write order, and the pointer MSBs toggle at wrap.
REQ-034 Reset mid-stream: drop resetn_i with 5 entries stored -> fifo_empty=1 and data_out=0 immediately, without waiting for a clock edge.
